circle_lines_stream: RTL and testbench

Parametrised successor to the fixed-width circle-lines generator. Given a centre and radius, it walks the midpoint (Bresenham) circle and streams pixel coordinates one per cycle. The output uses a valid/ready handshake with back-pressure. Two modes are selected at start: outline (8 octant points per step) and filled (every pixel of 4 horizontal spans per step). It sits between a command source and a pixel-writer or framebuffer port.

---
 rtl/circle_lines_pkg.sv | 21 ++
 rtl/circle_octant_mux.sv | 45 ++++
 rtl/circle_lines_stream.sv | 177 +++++++++++++++++
 tb/tb_circle_lines_stream.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/circle_lines_pkg.sv
// Shared types and decision-update constants for the midpoint circle streamer.
package circle_lines_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN_OUTLINE,
        RUN_FILL
    } state_t;

    typedef logic [2:0] octant_t;
    typedef logic [1:0] span_t;

    localparam int D_INIT  = 3;
    localparam int D_MUL   = 4;
    localparam int D_AXIAL = 6;
    localparam int D_DIAG  = 10;

    localparam octant_t LAST_OCTANT = 3'd7;
    localparam span_t   LAST_SPAN   = 2'd3;

endpackage

// File: rtl/circle_octant_mux.sv
// Maps the current step, octant/span index and span cursor to a pixel coordinate.
module circle_octant_mux
    import circle_lines_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] cx,
    input  logic [WIDTH-1:0] cy,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] cursor,
    input  logic             fill,
    input  octant_t          octant,
    input  span_t            span,
    output logic [WIDTH-1:0] _out0,
    output logic [WIDTH-1:0] _out1
);

    // Plain WIDTH-bit adds give the required two's-complement wrap for free.
    always_comb begin
        _out0 = cx;
        _out1 = cy;
        if (fill) begin
            _out0 = cx + cursor;
            case (span)
                2'd0:    _out1 = cy + y;
                2'd1:    _out1 = cy - y;
                2'd2:    _out1 = cy + x;
                default: _out1 = cy - x;
            endcase
        end else begin
            case (octant)
                3'd0: begin _out0 = cx + x; _out1 = cy + y; end
                3'd1: begin _out0 = cx + y; _out1 = cy + x; end
                3'd2: begin _out0 = cx - y; _out1 = cy + x; end
                3'd3: begin _out0 = cx - x; _out1 = cy + y; end
                3'd4: begin _out0 = cx - x; _out1 = cy - y; end
                3'd5: begin _out0 = cx - y; _out1 = cy - x; end
                3'd6: begin _out0 = cx + y; _out1 = cy - x; end
                default: begin _out0 = cx + x; _out1 = cy - y; end
            endcase
        end
    end

endmodule

// File: rtl/circle_lines_stream.sv
// Midpoint circle walker streaming outline or filled-span pixels over valid/ready.
module circle_lines_stream #(
    parameter int WIDTH = 32
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    _start,
    input  logic                    _mode,
    input  logic signed [WIDTH-1:0] cx,
    input  logic signed [WIDTH-1:0] cy,
    input  logic signed [WIDTH-1:0] r,
    input  logic                    _ready,
    output logic [WIDTH-1:0]        _out0,
    output logic [WIDTH-1:0]        _out1,
    output logic                    _valid,
    output logic                    _last,
    output logic                    _idle,
    output logic                    _done
);
    import circle_lines_pkg::*;

    localparam int EW = WIDTH + 3;
    typedef logic signed [EW-1:0] ext_t;

    localparam ext_t C_INIT  = ext_t'(D_INIT);
    localparam ext_t C_MUL   = ext_t'(D_MUL);
    localparam ext_t C_AXIAL = ext_t'(D_AXIAL);
    localparam ext_t C_DIAG  = ext_t'(D_DIAG);
    localparam ext_t C_ONE   = ext_t'(1);

    state_t           state, state_next;
    logic [WIDTH-1:0] cx_q, cx_next, cy_q, cy_next;
    ext_t             x_q, x_next, y_q, y_next, d_q, d_next, cur_q, cur_next;
    octant_t          oct_q, oct_next;
    span_t            span_q, span_next;
    logic             done_q, done_next;

    ext_t             r_ext, x_step, y_step, d_step, span_half;
    logic             more_steps, span_end, group_end, running;
    logic [WIDTH-1:0] pix_x, pix_y;

    assign r_ext = {{3{r[WIDTH-1]}}, r};

    // Step update uses the pre-update x and y; the current beat always belongs to the current step.
    always_comb begin
        x_step = x_q + C_ONE;
        if (!d_q[EW-1] && (d_q != '0)) begin
            d_step = d_q + (x_q - y_q) * C_MUL + C_DIAG;
            y_step = y_q - C_ONE;
        end else begin
            d_step = d_q + x_q * C_MUL + C_AXIAL;
            y_step = y_q;
        end
    end

    assign more_steps = (y_step >= x_step);
    assign span_half  = span_q[1] ? y_q : x_q;
    assign span_end   = (cur_q == span_half);
    assign running    = (state != IDLE);
    assign group_end  = (state == RUN_OUTLINE) ? (oct_q == LAST_OCTANT)
                                               : ((span_q == LAST_SPAN) && span_end);

    always_comb begin
        state_next = state;
        cx_next    = cx_q;
        cy_next    = cy_q;
        x_next     = x_q;
        y_next     = y_q;
        d_next     = d_q;
        oct_next   = oct_q;
        span_next  = span_q;
        cur_next   = cur_q;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (_start) begin
                    cx_next   = cx;
                    cy_next   = cy;
                    x_next    = '0;
                    y_next    = r_ext;
                    d_next    = C_INIT - r_ext - r_ext;
                    oct_next  = '0;
                    span_next = '0;
                    cur_next  = '0;
                    if (r[WIDTH-1]) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = _mode ? RUN_FILL : RUN_OUTLINE;
                    end
                end
            end
            RUN_OUTLINE: begin
                if (_ready) begin
                    if (oct_q != LAST_OCTANT) begin
                        oct_next = oct_q + 1'b1;
                    end else if (more_steps) begin
                        x_next   = x_step;
                        y_next   = y_step;
                        d_next   = d_step;
                        oct_next = '0;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            RUN_FILL: begin
                // Cursor is the x offset from the centre; spans 0/1 are +-x wide, spans 2/3 are +-y wide.
                if (_ready) begin
                    if (!span_end) begin
                        cur_next = cur_q + C_ONE;
                    end else if (span_q != LAST_SPAN) begin
                        span_next = span_q + 1'b1;
                        cur_next  = (span_q == 2'd0) ? -x_q : -y_q;
                    end else if (more_steps) begin
                        x_next    = x_step;
                        y_next    = y_step;
                        d_next    = d_step;
                        span_next = '0;
                        cur_next  = -x_step;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state  <= IDLE;
            cx_q   <= '0;
            cy_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            d_q    <= '0;
            oct_q  <= '0;
            span_q <= '0;
            cur_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            cx_q   <= cx_next;
            cy_q   <= cy_next;
            x_q    <= x_next;
            y_q    <= y_next;
            d_q    <= d_next;
            oct_q  <= oct_next;
            span_q <= span_next;
            cur_q  <= cur_next;
            done_q <= done_next;
        end
    end

    circle_octant_mux #(.WIDTH(WIDTH)) u_mux (
        .cx     (cx_q),
        .cy     (cy_q),
        .x      (x_q[WIDTH-1:0]),
        .y      (y_q[WIDTH-1:0]),
        .cursor (cur_q[WIDTH-1:0]),
        .fill   (state == RUN_FILL),
        .octant (oct_q),
        .span   (span_q),
        ._out0  (pix_x),
        ._out1  (pix_y)
    );

    assign _valid = running;
    assign _last  = running && group_end && !more_steps;
    assign _idle  = (state == IDLE);
    assign _done  = done_q;
    assign _out0  = running ? pix_x : '0;
    assign _out1  = running ? pix_y : '0;

endmodule

// File: tb/tb_circle_lines_stream.sv
// Randomised self-checking bench for circle_lines_stream against a queue-based circle model.
module tb_circle_lines_stream;

    localparam int WIDTH = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    mode;
    logic signed [WIDTH-1:0] cx, cy, r;
    logic                    ready;
    logic [WIDTH-1:0]        out0, out1;
    logic                    valid, last, idle, done;

    int n_vec  = 0;
    int n_miss = 0;
    logic [2*WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    circle_lines_stream #(.WIDTH(WIDTH)) dut (
        ._clock (clk),
        ._reset (rst),
        ._start (start),
        ._mode  (mode),
        .cx     (cx),
        .cy     (cy),
        .r      (r),
        ._ready (ready),
        ._out0  (out0),
        ._out1  (out1),
        ._valid (valid),
        ._last  (last),
        ._idle  (idle),
        ._done  (done)
    );

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic void pushPixel(input longint px, input longint py);
        logic [WIDTH-1:0] tx, ty;
        tx = px[WIDTH-1:0];
        ty = py[WIDTH-1:0];
        exp_q.push_back({tx, ty});
    endfunction

    // Reference: walk the circle with plain integer arithmetic and list every pixel in order.
    function automatic void buildExpected(input bit m, input longint cxv, input longint cyv, input longint rv);
        longint x, y, d;
        exp_q.delete();
        if (rv < 0) return;
        x = 0;
        y = rv;
        d = 3 - 2 * rv;
        while (y >= x) begin
            if (!m) begin
                pushPixel(cxv + x, cyv + y);
                pushPixel(cxv + y, cyv + x);
                pushPixel(cxv - y, cyv + x);
                pushPixel(cxv - x, cyv + y);
                pushPixel(cxv - x, cyv - y);
                pushPixel(cxv - y, cyv - x);
                pushPixel(cxv + y, cyv - x);
                pushPixel(cxv + x, cyv - y);
            end else begin
                for (longint i = -x; i <= x; i++) pushPixel(cxv + i, cyv + y);
                for (longint i = -x; i <= x; i++) pushPixel(cxv + i, cyv - y);
                for (longint i = -y; i <= y; i++) pushPixel(cxv + i, cyv + x);
                for (longint i = -y; i <= y; i++) pushPixel(cxv + i, cyv - x);
            end
            if (d > 0) begin
                d = d + 4 * (x - y) + 10;
                y = y - 1;
            end else begin
                d = d + 4 * x + 6;
            end
            x = x + 1;
        end
    endfunction

    // Runs one job: start, drain against the model with random/forced back-pressure, then check completion.
    task automatic applyStimulus(input bit m, input longint cxv, input longint cyv, input longint rv,
                                 input int ready_pct, input int stall_at, input int stall_len,
                                 input bit hold_start, input bit back_to_back);
        int beats, cycles, stall_cnt;
        bit stalled;
        logic [2*WIDTH-1:0] pix;
        logic [2*WIDTH:0]   held;
        if (!back_to_back) @(negedge clk);
        checkOutput("idle_before_start", idle, 1);
        start = 1'b1;
        mode  = m;
        cx    = cxv[WIDTH-1:0];
        cy    = cyv[WIDTH-1:0];
        r     = rv[WIDTH-1:0];
        ready = 1'b1;
        buildExpected(m, cxv, cyv, rv);
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        if (rv < 0) begin
            start = 1'b0;
            checkOutput("neg_r_done", done, 1);
            checkOutput("neg_r_idle", idle, 1);
            checkOutput("neg_r_valid", valid, 0);
            @(negedge clk);
            checkOutput("neg_r_done_single", done, 0);
            return;
        end
        checkOutput("first_valid", valid, 1);
        beats = 0;
        cycles = 0;
        stall_cnt = 0;
        stalled = 1'b0;
        held = '0;
        while (exp_q.size() != 0 && cycles < 4000) begin
            if (stalled) begin
                checkOutput("hold_x", out0, held[2*WIDTH:WIDTH+1]);
                checkOutput("hold_y", out1, held[WIDTH:1]);
                checkOutput("hold_last", last, held[0]);
            end
            checkOutput("valid_run", valid, 1);
            checkOutput("busy_idle", idle, 0);
            checkOutput("busy_done", done, 0);
            if (beats == stall_at && stall_cnt < stall_len) begin
                ready = 1'b0;
                stall_cnt++;
            end else begin
                ready = ($urandom_range(0, 99) < ready_pct);
            end
            if (ready) begin
                pix = exp_q.pop_front();
                checkOutput("beat_x", out0, pix[2*WIDTH-1:WIDTH]);
                checkOutput("beat_y", out1, pix[WIDTH-1:0]);
                checkOutput("beat_last", last, (exp_q.size() == 0));
                beats++;
                stalled = 1'b0;
            end else begin
                held = {out0, out1, last};
                stalled = 1'b1;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        if (exp_q.size() != 0) begin
            checkOutput("beat_budget", exp_q.size(), 0);
            exp_q.delete();
        end
        checkOutput("done_pulse", done, 1);
        checkOutput("idle_after", idle, 1);
        checkOutput("valid_after", valid, 0);
        ready = 1'b1;
    endtask

    initial begin
        longint rcx, rcy, rr;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        cx    = '0;
        cy    = '0;
        r     = '0;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_last", last, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_idle", idle, 1);
        checkOutput("rst_out0", out0, 0);
        checkOutput("rst_out1", out1, 0);
        rst = 1'b0;

        applyStimulus(1'b0, 23, 17, 5, 100, -1, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 23, 17, 5, 100, -1, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 23, 17, 5, 100, 10, 3, 1'b0, 1'b0);
        applyStimulus(1'b0, 23, 17, 0, 100, -1, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 23, 17, 0, 100, -1, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 23, 17, -1, 100, -1, 0, 1'b0, 1'b0);

        // Abort a fill job at beat 5, with a start in the reset cycle that must be ignored.
        @(negedge clk);
        start = 1'b1; mode = 1'b1; cx = 23; cy = 17; r = 5; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1; start = 1'b1; r = 3;
        @(negedge clk);
        checkOutput("midrst_valid", valid, 0);
        checkOutput("midrst_idle", idle, 1);
        checkOutput("midrst_done", done, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checkOutput("midrst_no_done", done, 0);
        checkOutput("midrst_no_start", valid, 0);
        applyStimulus(1'b0, 0, 0, 1, 100, -1, 0, 1'b0, 1'b0);

        applyStimulus(1'b1, 40, 9, 3, 70, -1, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 5, 5, 2, 100, -1, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 64'sd2147483647, 0, 2, 100, -1, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'sd2147483647, -3, 2, 80, -1, 0, 1'b0, 1'b1);

        for (int j = 0; j < 14; j++) begin
            rcx = longint'($urandom_range(0, 400)) - 200;
            rcy = longint'($urandom_range(0, 400)) - 200;
            rr  = longint'($urandom_range(0, 14)) - 2;
            applyStimulus(1'($urandom_range(0, 1)), rcx, rcy, rr,
                          int'($urandom_range(40, 100)), -1, 0,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
